// File: rtl/efuse_pkg.sv
// efuse_pkg: shared state encoding, CSR layout and helpers for the eFuse sequencer.
package efuse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_SENSE = 3'd1,
      ST_PG_SETUP = 3'd2,
      ST_PG_PULSE = 3'd3,
      ST_PG_GAP   = 3'd4,
      ST_VERIFY   = 3'd5,
      ST_ACK      = 3'd6
   } state_t;

   // CSR bit positions (bit 0 reads as zero)
   localparam int unsigned CSR_VERR_BIT  = 1;
   localparam int unsigned CSR_ARMED_BIT = 2;

   localparam logic [7:0] UNLOCK_KEY_DEFAULT = 8'hA5;

   // Lowest set bit of a mask; 0 for an empty mask (callers never program an empty mask)
   function automatic logic [2:0] first_set_bit(input logic [7:0] mask);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = mask[i] ? 3'(i) : idx;
      end
      return idx;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/efuse_bit_scan.sv
// efuse_bit_scan: finds the next set mask bit strictly above the bit just programmed.
module efuse_bit_scan
   import efuse_pkg::*;
(
   input  logic [7:0] mask,
   input  logic [2:0] cur_bit,
   output logic [2:0] next_bit,
   output logic       done
);

   logic [7:0] above_s;

   // keep only mask bits above cur_bit, then pick the lowest of them
   always_comb begin
      above_s  = 8'd0;
      next_bit = cur_bit;
      for (int i = 0; i < 8; i++) begin
         above_s[i] = mask[i] & (i > int'(cur_bit));
      end
      for (int i = 7; i >= 0; i--) begin
         next_bit = above_s[i] ? 3'(i) : next_bit;
      end
      done = (above_s == 8'd0);
   end

endmodule

// File: rtl/efuse_seq_ctrl.sv
// efuse_seq_ctrl: Wishbone slave that sequences sense and program pulses of one 64x8 eFuse macro.
module efuse_seq_ctrl
   import efuse_pkg::*;
#(
   parameter int unsigned SENSE_CYCLES = 4,
   parameter int unsigned SETUP_CYCLES = 8,
   parameter int unsigned PGM_CYCLES   = 200,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter logic [7:0]  UNLOCK_KEY   = UNLOCK_KEY_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [6:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [5:0]  fuse_addr_o,
   output logic [2:0]  fuse_bit_o,
   output logic        fuse_sense_o,
   output logic        fuse_pgm_o,
   output logic        fuse_vpp_en_o,
   input  logic [7:0]  fuse_q_i
);

   localparam int unsigned MAX_CYC = max2(max2(SENSE_CYCLES, SETUP_CYCLES),
                                          max2(PGM_CYCLES, GAP_CYCLES));
   localparam int CNT_W = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PGM_LOAD   = CNT_W'(PGM_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0]       mask_r;
   logic             armed_r;
   logic             verr_r;
   logic             ack_r;
   logic [31:0]      dat_r;
   logic [5:0]       addr_r;
   logic [2:0]       bit_r;
   logic             sense_r;
   logic             pgm_r;
   logic             vpp_r;

   logic             req_s;
   logic             cnt_zero_s;
   logic [31:0]      csr_s;
   logic [2:0]       next_bit_s;
   logic             scan_done_s;
   logic             unused_s;

   assign unused_s = ^wb_dat_i[31:16];

   // request decode, counter expiry and the CSR read image
   always_comb begin
      req_s                = wb_cyc_i & wb_stb_i;
      cnt_zero_s           = (cnt_r == CNT_ZERO);
      csr_s                = 32'd0;
      csr_s[CSR_ARMED_BIT] = armed_r;
      csr_s[CSR_VERR_BIT]  = verr_r;
   end

   efuse_bit_scan u_bit_scan (
      .mask     (mask_r),
      .cur_bit  (bit_r),
      .next_bit (next_bit_s),
      .done     (scan_done_s)
   );

   // sequencer FSM: owns all macro timing and every registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         mask_r  <= 8'd0;
         armed_r <= 1'b0;
         verr_r  <= 1'b0;
         ack_r   <= 1'b0;
         dat_r   <= 32'd0;
         addr_r  <= 6'd0;
         bit_r   <= 3'd0;
         sense_r <= 1'b0;
         pgm_r   <= 1'b0;
         vpp_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  if (wb_adr_i[6]) begin
                     // CSR access always completes in one cycle
                     if (wb_we_i) begin
                        armed_r <= (wb_dat_i[15:8] == UNLOCK_KEY);
                        if (wb_dat_i[CSR_VERR_BIT]) begin
                           verr_r <= 1'b0;
                        end else begin
                           verr_r <= verr_r;
                        end
                        dat_r <= 32'd0;
                     end else begin
                        dat_r <= csr_s;
                     end
                     ack_r   <= 1'b1;
                     state_r <= ST_ACK;
                  end else if (!wb_we_i) begin
                     addr_r  <= wb_adr_i[5:0];
                     sense_r <= 1'b1;
                     cnt_r   <= SENSE_LOAD;
                     state_r <= ST_RD_SENSE;
                  end else if (!armed_r) begin
                     // unarmed write: refuse without touching the macro
                     verr_r  <= 1'b1;
                     dat_r   <= 32'd0;
                     ack_r   <= 1'b1;
                     state_r <= ST_ACK;
                  end else begin
                     // the key arms exactly one write
                     armed_r <= 1'b0;
                     addr_r  <= wb_adr_i[5:0];
                     mask_r  <= wb_dat_i[7:0];
                     if (wb_dat_i[7:0] == 8'd0) begin
                        sense_r <= 1'b1;
                        cnt_r   <= SENSE_LOAD;
                        state_r <= ST_VERIFY;
                     end else begin
                        vpp_r   <= 1'b1;
                        cnt_r   <= SETUP_LOAD;
                        state_r <= ST_PG_SETUP;
                     end
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_RD_SENSE: begin
               if (cnt_zero_s) begin
                  dat_r   <= {24'd0, fuse_q_i};
                  sense_r <= 1'b0;
                  ack_r   <= 1'b1;
                  state_r <= ST_ACK;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_PG_SETUP: begin
               if (cnt_zero_s) begin
                  bit_r   <= first_set_bit(mask_r);
                  pgm_r   <= 1'b1;
                  cnt_r   <= PGM_LOAD;
                  state_r <= ST_PG_PULSE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_PG_PULSE: begin
               if (cnt_zero_s) begin
                  pgm_r   <= 1'b0;
                  cnt_r   <= GAP_LOAD;
                  state_r <= ST_PG_GAP;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_PG_GAP: begin
               if (cnt_zero_s) begin
                  if (scan_done_s) begin
                     // supply drops as the verify sense starts
                     vpp_r   <= 1'b0;
                     sense_r <= 1'b1;
                     cnt_r   <= SENSE_LOAD;
                     state_r <= ST_VERIFY;
                  end else begin
                     bit_r   <= next_bit_s;
                     pgm_r   <= 1'b1;
                     cnt_r   <= PGM_LOAD;
                     state_r <= ST_PG_PULSE;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_VERIFY: begin
               if (cnt_zero_s) begin
                  // only requested bits must read back blown
                  if ((fuse_q_i & mask_r) != mask_r) begin
                     verr_r <= 1'b1;
                  end else begin
                     verr_r <= verr_r;
                  end
                  dat_r   <= {24'd0, fuse_q_i};
                  sense_r <= 1'b0;
                  ack_r   <= 1'b1;
                  state_r <= ST_ACK;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_ACK: begin
               ack_r   <= 1'b0;
               state_r <= ST_IDLE;
            end

            default: begin
               ack_r   <= 1'b0;
               sense_r <= 1'b0;
               pgm_r   <= 1'b0;
               vpp_r   <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb_dat_o      = dat_r;
   assign wb_ack_o      = ack_r;
   assign fuse_addr_o   = addr_r;
   assign fuse_bit_o    = bit_r;
   assign fuse_sense_o  = sense_r;
   assign fuse_pgm_o    = pgm_r;
   assign fuse_vpp_en_o = vpp_r;

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// tb_efuse_seq_ctrl: directed plus randomized checks of efuse_seq_ctrl against a fuse-array model.
module tb_efuse_seq_ctrl;

   localparam int         SENSE = 4;
   localparam int         SETUP = 8;
   localparam int         PGM   = 200;
   localparam int         GAP   = 4;
   localparam logic [7:0] KEY   = 8'hA5;

   // per-cycle activity codes {vpp, pgm, sense, bit-while-pulsing}
   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_V    = 6'b100000;
   localparam logic [5:0] C_S    = 6'b001000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc   = 1'b0;
   logic        stb   = 1'b0;
   logic        we    = 1'b0;
   logic [6:0]  adr   = 7'd0;
   logic [31:0] wdat  = 32'd0;
   logic [31:0] rdat;
   logic        ack;
   logic [5:0]  faddr;
   logic [2:0]  fbit;
   logic        sense, pgm, vpp;
   logic [7:0]  fq;

   // physical macro: factory contents plus bits blown during the run
   bit   [7:0]  pre_mem   [64];
   bit   [7:0]  blown_mem [64];
   int          sense_age  = 0;
   int          pulse_len  = 0;
   int          fail_bit   = -1;
   logic [2:0]  pulse_bit  = 3'd0;
   logic [5:0]  pulse_addr = 6'd0;

   // reference model of architectural state
   logic [7:0]  exp_mem [64];
   logic        armed_m = 1'b0;
   logic        verr_m  = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [5:0]  tr_q[$];
   logic [5:0]  exp_q[$];

   always #5 clk = ~clk;

   efuse_seq_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_cyc_i      (cyc),
      .wb_stb_i      (stb),
      .wb_we_i       (we),
      .wb_adr_i      (adr),
      .wb_dat_i      (wdat),
      .wb_dat_o      (rdat),
      .wb_ack_o      (ack),
      .fuse_addr_o   (faddr),
      .fuse_bit_o    (fbit),
      .fuse_sense_o  (sense),
      .fuse_pgm_o    (pgm),
      .fuse_vpp_en_o (vpp),
      .fuse_q_i      (fq)
   );

   // sensed data is only valid once sense has been held long enough; otherwise garbage
   assign fq = (sense && sense_age >= SENSE - 1) ? (pre_mem[faddr] | blown_mem[faddr])
                                                 : ~(pre_mem[faddr] | blown_mem[faddr]);

   // macro behaviour: sense aging and blowing a bit after a full-width pulse
   always @(posedge clk) begin
      sense_age <= sense ? sense_age + 1 : 0;
      if (pgm && vpp && !sense) begin
         pulse_len  <= pulse_len + 1;
         pulse_bit  <= fbit;
         pulse_addr <= faddr;
      end else begin
         if (pulse_len >= PGM && int'(pulse_bit) != fail_bit)
            blown_mem[pulse_addr][pulse_bit] <= 1'b1;
         pulse_len <= 0;
      end
   end

   task automatic do_op(input logic w, input logic [6:0] a, input logic [31:0] d, input int drop);
      logic [7:0]  m, blown;
      logic        chk_dat;
      logic [31:0] exp_dat, got;
      int          lat, bad, nmin;
      exp_q.delete();
      tr_q.delete();
      chk_dat = 1'b0;
      exp_dat = 32'd0;
      // expected behaviour from the architectural rules
      if (a[6]) begin
         exp_q.push_back(C_IDLE);
         if (w) begin
            armed_m = (d[15:8] == KEY);
            if (d[1]) verr_m = 1'b0;
         end else begin
            chk_dat = 1'b1;
            exp_dat = {29'd0, armed_m, verr_m, 1'b0};
         end
      end else if (!w) begin
         repeat (SENSE) exp_q.push_back(C_S);
         exp_q.push_back(C_IDLE);
         chk_dat = 1'b1;
         exp_dat = {24'd0, exp_mem[a[5:0]]};
      end else if (!armed_m) begin
         exp_q.push_back(C_IDLE);
         verr_m = 1'b1;
      end else begin
         armed_m = 1'b0;
         m = d[7:0];
         if (m != 8'd0) begin
            repeat (SETUP) exp_q.push_back(C_V);
            for (int b = 0; b < 8; b++) begin
               if (m[b]) begin
                  repeat (PGM) exp_q.push_back({3'b110, 3'(b)});
                  repeat (GAP) exp_q.push_back(C_V);
               end
            end
         end
         repeat (SENSE) exp_q.push_back(C_S);
         exp_q.push_back(C_IDLE);
         blown = m;
         if (fail_bit >= 0) blown[fail_bit] = 1'b0;
         exp_mem[a[5:0]] = exp_mem[a[5:0]] | blown;
         if ((exp_mem[a[5:0]] & m) != m) verr_m = 1'b1;
         chk_dat = 1'b1;
         exp_dat = {24'd0, exp_mem[a[5:0]]};
      end

      // bus transfer with a bounded wait for ack
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      lat = 0;
      while (lat < 3000) begin
         @(negedge clk);
         lat++;
         tr_q.push_back({vpp, pgm, sense, pgm ? fbit : 3'd0});
         if (lat == drop) begin cyc = 1'b0; stb = 1'b0; end
         if (ack) break;
      end
      got = rdat;
      cyc = 1'b0; stb = 1'b0;

      checks++;
      assert (ack === 1'b1 && lat === exp_q.size())
         else begin errors++; $error("FAIL ack_latency adr=%0h observed=%0d expected=%0d", a, lat, exp_q.size()); end

      nmin = (tr_q.size() < exp_q.size()) ? tr_q.size() : exp_q.size();
      bad = -1;
      for (int i = 0; i < nmin; i++)
         if (bad < 0 && tr_q[i] !== exp_q[i]) bad = i;
      if (bad < 0 && tr_q.size() != exp_q.size()) bad = nmin;
      checks++;
      assert (bad == -1)
         else begin
            errors++;
            $error("FAIL trace adr=%0h cycle=%0d observed=%0h expected=%0h (len %0d vs %0d)", a, bad + 1,
                   (bad < tr_q.size()) ? tr_q[bad] : 6'h3f, (bad < exp_q.size()) ? exp_q[bad] : 6'h3f,
                   tr_q.size(), exp_q.size());
         end

      if (chk_dat) begin
         checks++;
         assert (got === exp_dat)
            else begin errors++; $error("FAIL rdata adr=%0h observed=%08h expected=%08h", a, got, exp_dat); end
      end

      @(negedge clk);
      checks++;
      assert (ack === 1'b0)
         else begin errors++; $error("FAIL ack_single_cycle adr=%0h observed=%b expected=0", a, ack); end
   endtask

   initial begin
      int         op;
      int         k;
      logic [7:0] kb;
      logic       found;

      for (int i = 0; i < 64; i++) begin
         pre_mem[i] = 8'($urandom) & 8'($urandom);
      end
      pre_mem[1]    = 8'h00;
      pre_mem[2]    = 8'h00;
      pre_mem[5]    = 8'h3C;
      pre_mem[6'h10] = 8'h00;
      pre_mem[6'h22] = 8'h00;
      for (int i = 0; i < 64; i++) exp_mem[i] = pre_mem[i];

      // reset state
      #12;
      checks++;
      assert ({ack, rdat, faddr, fbit, sense, pgm, vpp} === 45'd0)
         else begin errors++; $error("FAIL reset_outputs observed=%0h expected=0", {ack, rdat, faddr, fbit, sense, pgm, vpp}); end
      @(negedge clk);
      rst_n = 1'b1;

      do_op(1'b0, 7'h40, 32'd0, 0);                      // CSR reads zero
      do_op(1'b0, 7'h05, 32'd0, 0);                      // fuse read 0x3C
      do_op(1'b1, 7'h10, 32'h0000_00FF, 0);              // unarmed write rejected
      do_op(1'b0, 7'h40, 32'd0, 0);                      // verr visible
      do_op(1'b1, 7'h40, 32'h0000_0002, 0);              // W1C verr
      do_op(1'b1, 7'h40, 32'h0000_A500, 0);              // unlock
      do_op(1'b0, 7'h40, 32'd0, 0);                      // armed visible
      do_op(1'b1, 7'h01, 32'h0000_0081, 0);              // program bits 0 and 7
      do_op(1'b0, 7'h40, 32'd0, 0);                      // armed and verr clear
      do_op(1'b1, 7'h40, 32'h0000_A500, 0);
      fail_bit = 7;
      do_op(1'b1, 7'h02, 32'h0000_0081, 0);              // bit 7 refuses to blow
      fail_bit = -1;
      do_op(1'b0, 7'h40, 32'd0, 0);                      // verr set
      do_op(1'b1, 7'h40, 32'h0000_0002, 0);
      do_op(1'b0, 7'h40, 32'd0, 0);                      // verr cleared
      do_op(1'b1, 7'h40, 32'h0000_A500, 0);
      do_op(1'b1, 7'h03, 32'h0000_0000, 0);              // empty mask: sense only
      do_op(1'b1, 7'h03, 32'h0000_0055, 0);              // key consumed: rejected
      do_op(1'b0, 7'h40, 32'd0, 0);
      do_op(1'b0, 7'h05, 32'd0, 2);                      // request dropped early

      // randomized traffic
      for (k = 0; k < 12; k++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0: do_op(1'b0, {1'b0, 6'($urandom)}, 32'd0, 0);
            1: do_op(1'b0, {1'b1, 6'($urandom)}, 32'd0, 0);
            2: begin
               kb = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
               do_op(1'b1, {1'b1, 6'($urandom)}, {16'($urandom), kb, 6'd0, 1'($urandom), 1'b0}, 0);
            end
            3: begin
               do_op(1'b1, 7'h40, {16'd0, KEY, 8'd0}, 0);
               fail_bit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
               do_op(1'b1, {1'b0, 6'($urandom)}, {24'($urandom), 8'($urandom)}, 0);
               fail_bit = -1;
            end
            default: do_op(1'b1, {1'b0, 6'($urandom)}, {24'($urandom), 8'($urandom)}, 0);
         endcase
      end

      // asynchronous reset in the middle of the bit-3 pulse
      do_op(1'b1, 7'h40, 32'h0000_A500, 0);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h22; wdat = 32'h0000_000F;
      armed_m = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (pgm && fbit == 3'd3) found = 1'b1;
      end
      checks++;
      assert (found === 1'b1)
         else begin errors++; $error("FAIL bit3_pulse_seen observed=%b expected=1", found); end
      repeat (49) @(negedge clk);
      checks++;
      assert ({pgm, vpp, sense} === 3'b110)
         else begin errors++; $error("FAIL mid_pulse observed=%b expected=110", {pgm, vpp, sense}); end
      rst_n = 1'b0;
      #1;
      checks++;
      assert ({pgm, vpp, sense, ack} === 4'b0000)
         else begin errors++; $error("FAIL async_reset observed=%b expected=0000", {pgm, vpp, sense, ack}); end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      armed_m = 1'b0;
      verr_m  = 1'b0;
      exp_mem[6'h22] = exp_mem[6'h22] | 8'h07;           // bits 0..2 completed, bit 3 cut short
      do_op(1'b0, 7'h40, 32'd0, 0);
      do_op(1'b0, 7'h22, 32'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/efuse_seq_ctrl.md
Name: efuse_seq_ctrl

Overview:
- Wishbone-slave sequencer in chip_core that owns one 64x8 eFuse macro.
- Converts single-beat WB reads and writes into timed sense and per-bit program pulses, and returns the fuse data.
- Guards programming with an unlock key and a read-back verify; sticky error flag.
- One instance per fuse macro (two in chip_core).

Parameters:
- SENSE_CYCLES, 4, cycles fuse_sense_o stays high before fuse_q_i is sampled (>=1)
- SETUP_CYCLES, 8, cycles fuse_vpp_en_o is high before the first program pulse (>=1)
- PGM_CYCLES, 200, width of each fuse_pgm_o pulse in clk cycles (>=1)
- GAP_CYCLES, 4, low gap between consecutive bit pulses (>=1)
- UNLOCK_KEY, 8'hA5, key that arms one fuse write

Ports:
- clk  in  1  system clock (WB clock)
- rst_n  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  WB cycle
- wb_stb_i  in  1  WB strobe
- wb_we_i  in  1  WB write enable
- wb_adr_i  in  7  byte address; [6]=0 fuse byte [5:0], [6]=1 CSR
- wb_dat_i  in  32  write data; fuse byte in [7:0]
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  single-cycle acknowledge
- fuse_addr_o  out  6  macro row address
- fuse_bit_o  out  3  bit selected for programming
- fuse_sense_o  out  1  macro read/sense enable
- fuse_pgm_o  out  1  program pulse for the selected bit
- fuse_vpp_en_o  out  1  program supply enable
- fuse_q_i  in  8  sensed byte, valid once sense has been held for SENSE_CYCLES

Behaviour:
- Reset: all outputs 0, FSM in IDLE, armed=0, verr=0, counters 0. Reset mid-operation drops pgm/vpp/sense in the same instant (asynchronous).
- Request = wb_cyc_i & wb_stb_i, sampled in IDLE only. One request at a time. wb_ack_o pulses for 1 cycle, then the FSM returns to IDLE. The master must hold the request until ack.
- CSR read: ack next cycle. wb_dat_o = {29'b0, armed, verr, 1'b0}.
- CSR write, ack next cycle:
  - dat[15:8]==UNLOCK_KEY sets armed; any other value clears armed.
  - dat[1]=1 clears verr (W1C).
- Fuse read: IDLE -> RD_SENSE.
  - fuse_addr_o=adr[5:0]; sense high for SENSE_CYCLES cycles.
  - On the last cycle, latch fuse_q_i into wb_dat_o[7:0], drop sense, then ACK.
  - Latency = SENSE_CYCLES+1 cycles from request to ack.
- Fuse write with armed=0: no macro activity; ack next cycle; set verr.
- Fuse write with armed=1: latch dat[7:0] as the target mask, clear armed.
  - Zero mask: go straight to VERIFY.
  - Otherwise PG_SETUP: vpp_en=1 for SETUP_CYCLES.
  - PG_PULSE: for each set bit in ascending order, fuse_bit_o=bit, pgm=1 for PGM_CYCLES.
  - PG_GAP: pgm=0 for GAP_CYCLES. Clear bits are skipped with zero cycles spent.
  - After the last bit's gap: vpp_en=0, then VERIFY.
  - vpp_en stays high continuously from PG_SETUP through the last PG_GAP.
- VERIFY: sense for SENSE_CYCLES, then set verr if (fuse_q_i & mask) != mask. Then ACK; wb_dat_o[7:0] = sensed byte.
  - Bits that are already blown but outside the mask are not an error (OTR semantics).
- fuse_pgm_o is only ever high while fuse_vpp_en_o is high and fuse_sense_o is low; sense and pgm are never high together.
- Counters are sized $clog2(max param + 1). A counter loads param-1 on state entry and the state exits when it reaches 0.
- Request deasserted before ack (protocol violation): the sequence still completes and ack is still issued.

Decomposition:
- Package efuse_pkg: FSM state enum (IDLE, RD_SENSE, PG_SETUP, PG_PULSE, PG_GAP, VERIFY, ACK), CSR bit indices, UNLOCK_KEY default.
- One sub-module, efuse_bit_scan: given mask and current bit, outputs next set bit index and a done flag. It is combinational and used in the PG_GAP -> PG_PULSE decision.
- Everything else stays in efuse_seq_ctrl.

Test Plan:
- Fuse read, adr 0x05, model byte 0x3C: ack 5 cycles after request (SENSE_CYCLES=4), wb_dat_o=0x0000003C, pgm/vpp never high.
- Write without unlock, adr 0x10, data 0xFF: ack next cycle, no pgm pulse, CSR read returns 0x2 (verr).
- Unlock (CSR write 0x0000A500), then fuse write adr 0x01 data 0x81:
  - vpp high 8 cycles, then pgm on bit 0 for 200 cycles, 4-cycle gap, pgm on bit 7 for 200 cycles, 4-cycle gap, then sense.
  - Model blows the bits; wb_dat_o=0x81, verr=0, armed=0 afterwards.
- Same write, but the model fails to blow bit 7: ack with wb_dat_o=0x01, CSR=0x2. CSR write 0x2 clears it: CSR=0x0.
- Armed write with data 0x00: no vpp/pgm, sense only, ack, verr=0. A second write without re-unlocking is rejected.
- Assert rst_n low 50 cycles into the bit-3 pulse: pgm/vpp/sense go to 0 immediately, armed=0. After release, a read of the same address works normally.
